// File: rtl/pulse_meas_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_meas_pkg : shared types and defaults for the pulse interval meter    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pulse_meas_pkg;

    localparam int C_CNT_W   = 32;
    localparam int C_TIMEOUT = 1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pulse_interval_meter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_interval_meter_if : result valid/ready channel of the interval meter |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface pulse_interval_meter_if
    import pulse_meas_pkg::*;
#(
    parameter int CNT_W = C_CNT_W
);
    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] interval;
    logic             timeout_flag;

    modport master (
        output result_valid,
        output interval,
        output timeout_flag,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  interval,
        input  timeout_flag,
        output result_ready
    );
endinterface
`default_nettype wire

// File: rtl/interval_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | interval_stats : running min/max of accepted, non-timeout intervals        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module interval_stats
    import pulse_meas_pkg::*;
#(
    parameter int CNT_W = C_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             clr,
    input  wire logic             update,
    input  wire logic [CNT_W-1:0] value,
    output logic      [CNT_W-1:0] min_interval,
    output logic      [CNT_W-1:0] max_interval
);

    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;

    // Clear wins over an update landing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_min <= '1;
            r_max <= '0;
        end else if (clr) begin
            r_min <= '1;
            r_max <= '0;
        end else if (update) begin
            if (value < r_min) r_min <= value;
            if (value > r_max) r_max <= value;
        end
    end

    assign min_interval = r_min;
    assign max_interval = r_max;

endmodule
`default_nettype wire

// File: rtl/pulse_interval_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_interval_meter : clk-cycle interval from start to stop pulse, with   |
// | timeout, result presented over valid/ready. Optional min/max statistics    |
// | enabled by defining PULSE_INTERVAL_STATS_EN.                               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pulse_interval_meter
    import pulse_meas_pkg::*;
#(
    parameter int CNT_W   = C_CNT_W,
    parameter int TIMEOUT = C_TIMEOUT
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        enable,
    input  wire logic        start_i,
    input  wire logic        stop_i,
    pulse_interval_meter_if.master res,
    output logic             busy,
    output logic [15:0]      meas_count
`ifdef PULSE_INTERVAL_STATS_EN
    ,
    input  wire logic             stats_clr,
    output logic      [CNT_W-1:0] min_interval,
    output logic      [CNT_W-1:0] max_interval
`endif
);

    localparam logic [CNT_W-1:0] C_TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_interval;
    logic             r_timeout_flag;
    logic [15:0]      r_meas_count;
    logic             w_busy;
    logic             w_valid;
    logic             w_start_ok;
    logic             w_accept;
    logic             w_timeout;

    assign w_start_ok = enable & start_i;
    assign w_accept   = (r_state == DONE) & res.result_ready;
    assign w_timeout  = (r_cnt == C_TIMEOUT_V);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next_state = stop_i ? DONE : ARMED;
            ARMED:   if (stop_i || w_timeout) w_next_state = DONE;
            DONE:    if (w_accept) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            ARMED:   w_busy  = 1'b1;
            DONE:    w_valid = 1'b1;
            default: ;
        endcase
    end

    // cnt holds (current cycle - start cycle); it stops at TIMEOUT so never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt          <= '0;
            r_interval     <= '0;
            r_timeout_flag <= 1'b0;
            r_meas_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_cnt <= C_ONE;
                        if (stop_i) begin
                            r_interval     <= '0;
                            r_timeout_flag <= 1'b0;
                        end
                    end
                end
                ARMED: begin
                    if (stop_i) begin
                        r_interval     <= r_cnt;
                        r_timeout_flag <= 1'b0;
                    end else if (w_timeout) begin
                        r_interval     <= C_TIMEOUT_V;
                        r_timeout_flag <= 1'b1;
                    end else if (start_i) begin
                        r_cnt <= C_ONE;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                DONE: begin
                    if (w_accept) r_meas_count <= r_meas_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign res.result_valid = w_valid;
    assign res.interval     = r_interval;
    assign res.timeout_flag = r_timeout_flag;
    assign busy             = w_busy;
    assign meas_count       = r_meas_count;

`ifdef PULSE_INTERVAL_STATS_EN
    logic w_stats_update;
    assign w_stats_update = w_accept & ~r_timeout_flag;

    interval_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (stats_clr),
        .update       (w_stats_update),
        .value        (r_interval),
        .min_interval (min_interval),
        .max_interval (max_interval)
    );
`endif

endmodule
`default_nettype wire
